// File: rtl/lu_issue_ctrl_pkg.sv
// Shared constants and types for the logic-unit issue controller.
// Op-select encodings, FSM state encoding and datapath width.
package lu_issue_ctrl_pkg;

   localparam int unsigned LU_DATA_W = 32;

   localparam logic [1:0] LU_OP_NONE = 2'b00;
   localparam logic [1:0] LU_OP_AND  = 2'b01;
   localparam logic [1:0] LU_OP_OR   = 2'b10;
   localparam logic [1:0] LU_OP_XOR  = 2'b11;

   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StSettle = 2'b01,
      StResp   = 2'b10
   } lu_state_e;

endpackage

// File: rtl/lu_settle_cnt.sv
// Loadable 4-bit down-counter timing the logic unit settle window.
// Load has priority over decrement; zero is decoded from the register.
module lu_settle_cnt (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic       zero
);

   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != 4'd0)) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/lu_issue_ctrl.sv
// Requester-side sequencer for the 32-bit AND/OR/XOR logic unit: launches
// registered operands, waits the settle window, returns the captured result.
module lu_issue_ctrl
   import lu_issue_ctrl_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned CNT_W         = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [LU_DATA_W-1:0] req_a,
   input  logic [LU_DATA_W-1:0] req_b,
   input  logic [1:0]           req_op,
   output logic [LU_DATA_W-1:0] lu_a,
   output logic [LU_DATA_W-1:0] lu_b,
   output logic [1:0]           lu_f,
   input  logic [LU_DATA_W-1:0] lu_out,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [LU_DATA_W-1:0] rsp_data,
   output logic                 rsp_zero,
   output logic                 rsp_illegal,
   output logic                 busy,
   output logic [CNT_W-1:0]     op_count
);

   localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);

   lu_state_e            state_q, state_d;
   logic [LU_DATA_W-1:0] lu_a_q, lu_a_d;
   logic [LU_DATA_W-1:0] lu_b_q, lu_b_d;
   logic [1:0]           lu_f_q, lu_f_d;
   logic [LU_DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic                 rsp_zero_q, rsp_zero_d;
   logic                 rsp_illegal_q, rsp_illegal_d;
   logic [CNT_W-1:0]     op_count_q, op_count_d;
   logic                 cnt_load, cnt_dec, cnt_zero;

   lu_settle_cnt u_settle_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (SettleLoad),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_d       = state_q;
      lu_a_d        = lu_a_q;
      lu_b_d        = lu_b_q;
      lu_f_d        = lu_f_q;
      rsp_data_d    = rsp_data_q;
      rsp_zero_d    = rsp_zero_q;
      rsp_illegal_d = rsp_illegal_q;
      op_count_d    = op_count_q;
      cnt_load      = 1'b0;
      cnt_dec       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               lu_a_d = req_a;
               lu_b_d = req_b;
               lu_f_d = req_op;
               if (req_op == LU_OP_NONE) begin
                  // Illegal op has nothing to settle; answer at once.
                  rsp_data_d    = '0;
                  rsp_zero_d    = 1'b1;
                  rsp_illegal_d = 1'b1;
                  state_d       = StResp;
               end else begin
                  cnt_load = 1'b1;
                  state_d  = StSettle;
               end
            end
         end
         StSettle: begin
            if (cnt_zero) begin
               rsp_data_d    = lu_out;
               rsp_zero_d    = (lu_out == '0);
               rsp_illegal_d = 1'b0;
               state_d       = StResp;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               op_count_d = op_count_q + CNT_W'(1);
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         lu_a_q        <= '0;
         lu_b_q        <= '0;
         lu_f_q        <= '0;
         rsp_data_q    <= '0;
         rsp_zero_q    <= 1'b0;
         rsp_illegal_q <= 1'b0;
         op_count_q    <= '0;
      end else begin
         state_q       <= state_d;
         lu_a_q        <= lu_a_d;
         lu_b_q        <= lu_b_d;
         lu_f_q        <= lu_f_d;
         rsp_data_q    <= rsp_data_d;
         rsp_zero_q    <= rsp_zero_d;
         rsp_illegal_q <= rsp_illegal_d;
         op_count_q    <= op_count_d;
      end
   end

   assign req_ready   = (state_q == StIdle);
   assign rsp_valid   = (state_q == StResp);
   assign busy        = (state_q != StIdle);
   assign lu_a        = lu_a_q;
   assign lu_b        = lu_b_q;
   assign lu_f        = lu_f_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_zero    = rsp_zero_q;
   assign rsp_illegal = rsp_illegal_q;
   assign op_count    = op_count_q;

endmodule

// File: doc/lu_issue_ctrl.md
Name: lu_issue_ctrl

Overview:
Requester-side sequencer for the 32-bit bitwise logic unit (AND/OR/XOR selected by a 2-bit f).
- Accepts operation requests over a valid/ready handshake.
- Drives registered, stable operands and f into the combinational logic unit.
- Waits a fixed number of settle cycles to cover the unit's gate-plus-mux delay, then captures the result.
- Returns the result, with flags, over a second valid/ready handshake.

Parameters:
SETTLE_CYCLES, 2, clock edges between operand launch and result capture; legal range 1..15.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request
req_a  input  32  operand A
req_b  input  32  operand B
req_op  input  2  op select: 00 none/illegal, 01 AND, 10 OR, 11 XOR
lu_a  output  32  registered operand A to the logic unit
lu_b  output  32  registered operand B to the logic unit
lu_f  output  2  registered select to the logic unit
lu_out  input  32  logic unit result
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts the response
rsp_data  output  32  captured result
rsp_zero  output  1  rsp_data == 0
rsp_illegal  output  1  request had op 00
busy  output  1  state != IDLE
op_count  output  CNT_W  responses completed

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: state IDLE; all outputs 0 except req_ready = 1. Cleared outputs are lu_a, lu_b, lu_f, rsp_data, rsp_zero, rsp_illegal, rsp_valid, busy, op_count, and the settle counter.
- Reset mid-operation: in-flight request is discarded, rsp_valid drops immediately, and no response is produced for it.
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - req_ready = 1.
  - On a rising edge with req_valid = 1: latch req_a/req_b/req_op into lu_a/lu_b/lu_f.
  - If req_op != 00: load cnt = SETTLE_CYCLES-1 and go to SETTLE.
  - If req_op == 00: rsp_data = 0, rsp_zero = 1, rsp_illegal = 1; go directly to RESP (no settle).
- SETTLE:
  - req_ready = 0; lu_* held constant.
  - Each edge with cnt != 0 decrements cnt.
  - At the edge where cnt == 0: rsp_data = lu_out, rsp_zero = (lu_out == 0), rsp_illegal = 0; go to RESP.
- RESP:
  - rsp_valid = 1; rsp_data and flags held stable while rsp_ready = 0 (no drop, no change).
  - On an edge with rsp_ready = 1: op_count += 1 (wraps at 2^CNT_W to 0) and go to IDLE.
  - rsp_valid deasserts in the following cycle. Illegal responses are counted.
- Latency: accept edge E0, capture at edge E(SETTLE_CYCLES), rsp_valid high from that edge. With the default value, rsp_valid rises 2 edges after accept.
- Throughput: no accept during RESP. Minimum request-to-request spacing is SETTLE_CYCLES+2 edges when rsp_ready is tied high.
- lu_a/lu_b/lu_f hold their last values in IDLE; they change only on an accepted request.
- req_* inputs are ignored outside IDLE. req_valid held high across a response is accepted on the first IDLE edge.
- All outputs are registered or decoded from state only; there is no combinational path from req_* or rsp_ready to any output.

Decomposition:
- Shared package: LU_OP_NONE = 2'b00, LU_OP_AND = 2'b01, LU_OP_OR = 2'b10, LU_OP_XOR = 2'b11; state encodings IDLE/SETTLE/RESP; data width constant 32.
- One sub-module: lu_settle_cnt, a loadable 4-bit down-counter with async active-low clear, providing a zero flag. The FSM and capture registers stay in lu_issue_ctrl.
- The bench instantiates the existing logic unit on lu_a/lu_b/lu_f -> lu_out.

Test Plan:
- Reset: assert rst_n = 0 mid-SETTLE -> all outputs 0, req_ready = 1, no rsp_valid after release.
- AND: A = 0xF0F0_1234, B = 0x0FF0_FFFF, op = 01 -> rsp_data = 0x00F0_1234, rsp_zero = 0, rsp_valid exactly 2 edges after accept.
- XOR zero: A = B = 0xDEAD_BEEF, op = 11 -> rsp_data = 0, rsp_zero = 1.
- OR with backpressure: A = 0x0000_00FF, B = 0xFF00_0000, op = 10, rsp_ready low 5 cycles -> rsp_data = 0xFF00_00FF held stable, req_ready = 0 throughout, op_count increments once on release.
- Illegal op: op = 00 -> rsp_illegal = 1, rsp_data = 0, rsp_valid 1 edge after accept, op_count increments.
- Wrap: preload by issuing 65536 requests (CNT_W = 16) with rsp_ready = 1 -> op_count returns to 0; request spacing = 4 edges.
